// File: rtl/arith_op_sequencer.sv
// Operand/operation sequencer for the calculator datapath: captures two operands and an
// operation from buttons, launches an operator via start/done and holds its result for display.
module arith_op_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [3:0]       btn,
    output logic [WIDTH-1:0] opd_a,
    output logic [WIDTH-1:0] opd_b,
    output logic [1:0]       op_sel,
    output logic             op_start,
    input  logic             op_done,
    input  logic [WIDTH-1:0] op_result,
    input  logic             op_overflow,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             timeout,
    output logic             result_valid,
    output logic [2:0]       state_o
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StGetA   = 3'd1,
        StGetB   = 3'd2,
        StExec   = 3'd3,
        StResult = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opd_a_q, opd_a_d;
    logic [WIDTH-1:0] opd_b_q, opd_b_d;
    logic [1:0]       op_sel_q, op_sel_d;
    logic             op_start_q, op_start_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             timeout_q, timeout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             press;
    logic [1:0]       btn_sel;

    assign press = |btn;

    // Button priority FiM > FiA > FlM > FlA, encoded as {fixed, mult}.
    always_comb begin
        btn_sel = 2'b00;
        if (btn[3]) begin
            btn_sel = 2'b11;
        end else if (btn[2]) begin
            btn_sel = 2'b10;
        end else if (btn[1]) begin
            btn_sel = 2'b01;
        end
    end

    always_comb begin
        state_d    = state_q;
        opd_a_d    = opd_a_q;
        opd_b_d    = opd_b_q;
        op_sel_d   = op_sel_q;
        op_start_d = 1'b0;
        result_d   = result_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        case (state_q)
            StIdle: begin
                if (press) state_d = StGetA;
            end
            StGetA: begin
                if (press) begin
                    opd_a_d = sw;
                    state_d = StGetB;
                end
            end
            StGetB: begin
                if (press) begin
                    opd_b_d    = sw;
                    op_sel_d   = btn_sel;
                    op_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StExec;
                end
            end
            StExec: begin
                if (op_done) begin
                    result_d   = op_result;
                    overflow_d = op_overflow;
                    timeout_d  = 1'b0;
                    state_d    = StResult;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    result_d   = '0;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = StResult;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResult: begin
                if (press) state_d = StGetA;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            opd_a_q    <= '0;
            opd_b_q    <= '0;
            op_sel_q   <= 2'b00;
            op_start_q <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            opd_a_q    <= opd_a_d;
            opd_b_q    <= opd_b_d;
            op_sel_q   <= op_sel_d;
            op_start_q <= op_start_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign opd_a        = opd_a_q;
    assign opd_b        = opd_b_q;
    assign op_sel       = op_sel_q;
    assign op_start     = op_start_q;
    assign result       = result_q;
    assign overflow     = overflow_q;
    assign timeout      = timeout_q;
    assign result_valid = (state_q == StResult);
    assign state_o      = state_q;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Directed bench for arith_op_sequencer: a 16-bit instance with TIMEOUT=4 and an 8-bit instance.
module tb_arith_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] sw16 = '0;
    logic [3:0]  btn16 = '0;
    logic [15:0] opd_a16, opd_b16, result16, op_result16 = '0;
    logic [1:0]  op_sel16;
    logic        op_start16, op_done16 = 1'b0, op_ovf16 = 1'b0;
    logic        overflow16, timeout16, rvalid16;
    logic [2:0]  state16;

    logic [7:0]  sw8 = '0;
    logic [3:0]  btn8 = '0;
    logic [7:0]  opd_a8, opd_b8, result8, op_result8 = '0;
    logic [1:0]  op_sel8;
    logic        op_start8, op_done8 = 1'b0, op_ovf8 = 1'b0;
    logic        overflow8, timeout8, rvalid8;
    logic [2:0]  state8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arith_op_sequencer #(.WIDTH(16), .TIMEOUT(4)) dut16 (
        .clk(clk), .rst(rst), .sw(sw16), .btn(btn16),
        .opd_a(opd_a16), .opd_b(opd_b16), .op_sel(op_sel16), .op_start(op_start16),
        .op_done(op_done16), .op_result(op_result16), .op_overflow(op_ovf16),
        .result(result16), .overflow(overflow16), .timeout(timeout16),
        .result_valid(rvalid16), .state_o(state16)
    );

    arith_op_sequencer #(.WIDTH(8), .TIMEOUT(255)) dut8 (
        .clk(clk), .rst(rst), .sw(sw8), .btn(btn8),
        .opd_a(opd_a8), .opd_b(opd_b8), .op_sel(op_sel8), .op_start(op_start8),
        .op_done(op_done8), .op_result(op_result8), .op_overflow(op_ovf8),
        .result(result8), .overflow(overflow8), .timeout(timeout8),
        .result_valid(rvalid8), .state_o(state8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press16(input logic [3:0] b, input logic [15:0] v);
        sw16  = v;
        btn16 = b;
        step();
        btn16 = '0;
    endtask

    task automatic press8(input logic [3:0] b, input logic [7:0] v);
        sw8  = v;
        btn8 = b;
        step();
        btn8 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step();
        check_eq("rst_state", state16, 0);
        check_eq("rst_start", op_start16, 0);
        check_eq("rst_result", result16, 0);
        check_eq("rst_rvalid", rvalid16, 0);
        rst = 1'b0;
        step();

        // Basic flow with FlM
        press16(4'b0001, 16'h0000);
        check_eq("idle_to_geta", state16, 1);
        check_eq("idle_no_capture", opd_a16, 0);
        press16(4'b0001, 16'h1234);
        check_eq("geta_state", state16, 2);
        check_eq("opd_a", opd_a16, 16'h1234);
        press16(4'b0010, 16'h0042);
        check_eq("exec_state", state16, 3);
        check_eq("opd_b", opd_b16, 16'h0042);
        check_eq("op_sel_flm", op_sel16, 2'b01);
        check_eq("op_start_first", op_start16, 1);
        btn16 = 4'b1111;
        step();
        btn16 = '0;
        check_eq("exec_btn_ignored", state16, 3);
        check_eq("op_start_one_cycle", op_start16, 0);
        op_done16 = 1'b1;
        op_result16 = 16'hBEEF;
        step();
        op_done16 = 1'b0;
        check_eq("flow_result", result16, 16'hBEEF);
        check_eq("flow_rvalid", rvalid16, 1);
        check_eq("flow_state", state16, 4);
        check_eq("flow_timeout", timeout16, 0);
        check_eq("opd_a_held", opd_a16, 16'h1234);

        // Restart from RESULT
        press16(4'b0001, 16'h0000);
        check_eq("restart_state", state16, 1);
        check_eq("restart_rvalid", rvalid16, 0);
        check_eq("restart_result_held", result16, 16'hBEEF);

        // Same-cycle done plus button priority
        press16(4'b0001, 16'h0005);
        press16(4'b1011, 16'h0006);
        check_eq("prio_sel", op_sel16, 2'b11);
        check_eq("prio_start", op_start16, 1);
        op_done16 = 1'b1;
        op_ovf16 = 1'b1;
        op_result16 = 16'h7777;
        step();
        op_done16 = 1'b0;
        op_ovf16 = 1'b0;
        check_eq("same_state", state16, 4);
        check_eq("same_ovf", overflow16, 1);
        check_eq("same_timeout", timeout16, 0);
        check_eq("same_result", result16, 16'h7777);

        // Timeout: op_done outside EXEC must be ignored, then 4 EXEC cycles without done
        op_done16 = 1'b1;
        press16(4'b0001, 16'h0000);
        op_done16 = 1'b0;
        check_eq("done_outside_exec", state16, 1);
        press16(4'b0001, 16'h0011);
        press16(4'b0100, 16'h0022);
        check_eq("to_sel_fia", op_sel16, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("to_still_exec", state16, 3);
        end
        step();
        check_eq("to_state", state16, 4);
        check_eq("to_flag", timeout16, 1);
        check_eq("to_result", result16, 0);
        check_eq("to_ovf", overflow16, 0);

        // Asynchronous reset mid-EXEC
        press16(4'b0001, 16'h0000);
        press16(4'b0001, 16'hAAAA);
        press16(4'b1000, 16'h5555);
        check_eq("ar_start_before", op_start16, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("ar_start", op_start16, 0);
        check_eq("ar_state", state16, 0);
        check_eq("ar_opd_a", opd_a16, 0);
        check_eq("ar_opd_b", opd_b16, 0);
        check_eq("ar_sel", op_sel16, 0);
        check_eq("ar_timeout", timeout16, 0);
        check_eq("ar_result", result16, 0);
        #1 rst = 1'b0;
        step();

        // 8-bit instance full flow
        press8(4'b0001, 8'h00);
        press8(4'b0001, 8'hFF);
        press8(4'b0001, 8'h01);
        check_eq("w8_opd_a", opd_a8, 8'hFF);
        check_eq("w8_opd_b", opd_b8, 8'h01);
        check_eq("w8_sel", op_sel8, 2'b00);
        op_done8 = 1'b1;
        op_ovf8 = 1'b1;
        op_result8 = 8'h00;
        step();
        op_done8 = 1'b0;
        op_ovf8 = 1'b0;
        check_eq("w8_state", state8, 4);
        check_eq("w8_ovf", overflow8, 1);
        check_eq("w8_result", result8, 0);
        check_eq("w8_rvalid", rvalid8, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
